// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/acknowledge bundle for mem_access_ctrl.
// The master drives the request; the slave returns completion status and read data.
interface mem_access_ctrl_if #(
    parameter int unsigned ADLINES   = 16,
    parameter int unsigned DATALINES = 16
);
    logic                 req;
    logic                 wr;
    logic [ADLINES-1:0]   addr;
    logic [DATALINES-1:0] wdata;
    logic                 ack;
    logic                 busy;
    logic                 err;
    logic [DATALINES-1:0] rdata;

    modport master (output req, wr, addr, wdata, input ack, busy, err, rdata);
    modport slave  (input req, wr, addr, wdata, output ack, busy, err, rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a level-sensitive RAM, with setup and hold cycles around each strobe.
// Optional MEMCTRL_VERIFY_EN adds a read-back VERIFY state after every store.
module mem_access_ctrl #(
    parameter int unsigned ADLINES     = 16,
    parameter int unsigned DATALINES   = 16,
    parameter int unsigned RAMSIZE     = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_ctrl_if.slave     cpu,
    output logic [ADLINES-1:0]   ram_address,
    output logic [DATALINES-1:0] ram_datain,
    output logic                 ram_read,
    output logic                 ram_write,
    input  logic [DATALINES-1:0] ram_dataout
);
    localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [ADLINES:0] RAM_LIMIT = (ADLINES + 1)'(RAMSIZE);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
`ifdef MEMCTRL_VERIFY_EN
        VERIFY,
`endif
        DONE
    } state_t;

    state_t               state, state_next;
    logic [ADLINES-1:0]   addr_q;
    logic [DATALINES-1:0] wdata_q;
    logic                 wr_q;
    logic                 err_q;
    logic [DATALINES-1:0] rdata_q;
    logic [CW-1:0]        cnt;
    logic                 in_range;
    logic                 accept;
    logic                 strobe_last;

    assign in_range    = {1'b0, cpu.addr} < RAM_LIMIT;
    assign accept      = (state == IDLE) && cpu.req;
    assign strobe_last = (state == STROBE) && (cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Strobes are decoded from the state register only, so an asynchronous
    // reset removes them immediately without waiting for an edge.
    always_comb begin
        state_next = state;
        ram_read   = 1'b0;
        ram_write  = 1'b0;
        case (state)
            IDLE:   if (cpu.req) state_next = in_range ? SETUP : DONE;
            SETUP: begin
                ram_read   = !wr_q;
                state_next = STROBE;
            end
            STROBE: begin
                ram_read  = !wr_q;
                ram_write = wr_q;
                if (cnt == CW'(1)) state_next = wr_q ? HOLD : DONE;
            end
`ifdef MEMCTRL_VERIFY_EN
            HOLD:   state_next = VERIFY;
            VERIFY: begin
                ram_read   = 1'b1;
                state_next = DONE;
            end
`else
            HOLD:   state_next = DONE;
`endif
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cpu.addr;
                wdata_q <= cpu.wdata;
                wr_q    <= cpu.wr;
                err_q   <= !in_range;
            end
            if (state == SETUP)       cnt <= CW'(WAIT_CYCLES);
            else if (state == STROBE) cnt <= cnt - CW'(1);
            if (strobe_last && !wr_q) rdata_q <= ram_dataout;
`ifdef MEMCTRL_VERIFY_EN
            if (state == VERIFY)      err_q <= (ram_dataout != wdata_q);
`endif
        end
    end

    assign ram_address = addr_q;
    assign ram_datain  = wdata_q;
    assign cpu.ack     = (state == DONE);
    assign cpu.busy    = (state != IDLE);
    assign cpu.err     = err_q;
    assign cpu.rdata   = rdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (RAMSIZE=256, WAIT_CYCLES=1) against a small RAM model.
// Build with MEMCTRL_VERIFY_EN defined to also cover the read-back verify path.
module tb_mem_access_ctrl;
`ifdef MEMCTRL_VERIFY_EN
    localparam int STORE_LAT = 4;
    localparam int STORE_RD  = 1;
`else
    localparam int STORE_LAT = 3;
    localparam int STORE_RD  = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ram_address, ram_datain, ram_dataout;
    logic        ram_read, ram_write;
    logic [15:0] mem [0:255];
    logic        stuck0 = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          ack_pulses = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADLINES(16), .DATALINES(16)) bus ();

    mem_access_ctrl #(
        .ADLINES(16), .DATALINES(16), .RAMSIZE(256), .WAIT_CYCLES(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu(bus),
        .ram_address(ram_address),
        .ram_datain(ram_datain),
        .ram_read(ram_read),
        .ram_write(ram_write),
        .ram_dataout(ram_dataout)
    );

    always @(posedge clk) if (ram_write) mem[ram_address[7:0]] <= ram_datain;
    assign ram_dataout = mem[ram_address[7:0]] & {15'h7fff, ~stuck0};

    always @(posedge clk) if (bus.ack) ack_pulses <= ack_pulses + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return {11'd0, bus.ack, bus.busy, bus.err, bus.rdata, ram_address, ram_datain,
                ram_read, ram_write};
    endfunction

    // Issues one access, scrambles the request inputs while busy, and traces until ack.
    task automatic run_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                              output int edges, output int rc, output int wc,
                              output int bad, output logic e);
        bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
        tick();
        bus.req = 1'b0; bus.wr = ~w; bus.addr = ~a; bus.wdata = ~d;
        edges = 0; rc = 0; wc = 0; bad = 0;
        while (!bus.ack && edges < 20) begin
            rc += int'(ram_read);
            wc += int'(ram_write);
            if (ram_read && ram_write) bad++;
            if (ram_address !== a || ram_datain !== d) bad++;
            tick();
            edges++;
        end
        e = bus.err;
        tick();
        check_val("ack_single_cycle", {62'd0, bus.ack, bus.busy}, 64'd0);
    endtask

    int   edges, rc, wc, bad, n, pulses;
    logic e;

    initial begin
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        #2;
        check_val("reset_outputs", all_outputs(), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Reset in the middle of a store strobe
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 16'd5; bus.wdata = 16'h5555;
        tick();
        bus.req = 1'b0;
        check_val("setup_no_write", {47'd0, ram_write, ram_address}, {47'd0, 1'b0, 16'd5});
        tick();
        check_val("strobe_write", {63'd0, ram_write}, 64'd1);
        pulses = ack_pulses;
        #2 reset = 1'b1;
        #1 check_val("reset_mid_strobe", all_outputs(), 64'd0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check_val("no_ack_after_reset", 64'(ack_pulses), 64'(pulses));

        // Store 0x00AB to 16
        run_access(1'b1, 16'd16, 16'h00AB, edges, rc, wc, bad, e);
        check_val("store16_latency", 64'(edges), 64'(STORE_LAT));
        check_val("store16_write_cycles", 64'(wc), 64'd1);
        check_val("store16_read_cycles", 64'(rc), 64'(STORE_RD));
        check_val("store16_stable", 64'(bad), 64'd0);
        check_val("store16_err", {63'd0, e}, 64'd0);

        // Load from 16
        run_access(1'b0, 16'd16, 16'h0000, edges, rc, wc, bad, e);
        check_val("load16_latency", 64'(edges), 64'd2);
        check_val("load16_read_cycles", 64'(rc), 64'd2);
        check_val("load16_write_cycles", 64'(wc), 64'd0);
        check_val("load16_stable", 64'(bad), 64'd0);
        check_val("load16_err", {63'd0, e}, 64'd0);
        check_val("load16_rdata", 64'(bus.rdata), 64'h00AB);

        // Out-of-range load: DONE entered on the accepting edge, no strobe
        run_access(1'b0, 16'd300, 16'h0000, edges, rc, wc, bad, e);
        check_val("oor_latency", 64'(edges), 64'd0);
        check_val("oor_strobes", 64'(rc + wc), 64'd0);
        check_val("oor_err", {63'd0, e}, 64'd1);
        check_val("oor_rdata_kept", 64'(bus.rdata), 64'h00AB);

        // Back-to-back store/load with req held high
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 16'd3; bus.wdata = 16'h1234;
        tick();
        bus.addr = 16'd7; bus.wdata = 16'hFFFF;
        n = 0; bad = 0;
        while (!bus.ack && n < 20) begin
            if (ram_address !== 16'd3 || ram_datain !== 16'h1234) bad++;
            tick();
            n++;
        end
        check_val("b2b_store_latency", 64'(n), 64'(STORE_LAT));
        check_val("b2b_busy_inputs_ignored", 64'(bad), 64'd0);
        check_val("b2b_err_cleared", {63'd0, bus.err}, 64'd0);
        bus.wr = 1'b0; bus.addr = 16'd3;
        tick();
        check_val("b2b_idle_gap", {63'd0, bus.busy}, 64'd0);
        tick();
        bus.req = 1'b0;
        check_val("b2b_load_accept", {46'd0, bus.busy, ram_read, ram_address},
                  {46'd0, 1'b1, 1'b1, 16'd3});
        n = 0;
        while (!bus.ack && n < 20) begin
            tick();
            n++;
        end
        check_val("b2b_load_latency", 64'(n), 64'd2);
        check_val("b2b_load_rdata", 64'(bus.rdata), 64'h1234);
        tick();

        // Address boundary: 255 is the last word, 256 is rejected
        run_access(1'b1, 16'd255, 16'hBEEF, edges, rc, wc, bad, e);
        check_val("store255_err", {63'd0, e}, 64'd0);
        run_access(1'b0, 16'd255, 16'h0000, edges, rc, wc, bad, e);
        check_val("load255_rdata", 64'(bus.rdata), 64'hBEEF);
        check_val("load255_err", {63'd0, e}, 64'd0);
        run_access(1'b0, 16'd256, 16'h0000, edges, rc, wc, bad, e);
        check_val("load256_err", {63'd0, e}, 64'd1);
        check_val("load256_strobes", 64'(rc + wc), 64'd0);
        check_val("load256_rdata_kept", 64'(bus.rdata), 64'hBEEF);

`ifdef MEMCTRL_VERIFY_EN
        stuck0 = 1'b1;
        run_access(1'b1, 16'd8, 16'h0001, edges, rc, wc, bad, e);
        check_val("verify_stuck_latency", 64'(edges), 64'd4);
        check_val("verify_stuck_err", {63'd0, e}, 64'd1);
        check_val("verify_rdata_kept", 64'(bus.rdata), 64'hBEEF);
        stuck0 = 1'b0;
        run_access(1'b1, 16'd9, 16'h0001, edges, rc, wc, bad, e);
        check_val("verify_good_err", {63'd0, e}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
